grid_game_engine: RTL and testbench
===================================

Name: grid_game_engine

Overview:
- Parametrised N×N, K-in-a-row two-party board game engine; successor to the fixed 3×3 tic-tac-toe datapath and controller.
- Holds the board and enforces turn order. Validates each move through a valid/ready handshake, then walks the lines through the placed cell to detect a win, and also detects a draw.
- Sits between the player/computer move sources and the display/scoring logic; those read cells through a random-access read port.

Parameters:
- N, 3, board side length; legal range 3..8.
- K, 3, run length needed to win; legal range 3..N.
- CW, $clog2(N) (min 1), width of row/col indices (derived).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse; clears the board and begins a new game
- first_player  in  1  side that moves first after start (0=player, 1=computer)
- move_valid  in  1  move request
- move_ready  out  1  engine can accept a move
- move_side  in  1  side issuing the move (0=player, 1=computer)
- move_row  in  CW  target row
- move_col  in  CW  target column
- move_ack  out  1  one-cycle pulse: move accepted
- move_illegal  out  1  one-cycle pulse: move rejected
- rd_row  in  CW  read port row
- rd_col  in  CW  read port column
- rd_cell  out  2  combinational cell contents: 00 empty, 01 player, 10 computer; 00 if out of range
- turn  out  1  side expected to move next
- busy  out  1  high in CHECK state
- game_over  out  1  game finished
- winner  out  2  01 player, 10 computer, 00 none/draw
- draw  out  1  board full, no winner
- move_count  out  $clog2(N*N+1)  accepted moves this game

Behaviour:
- Reset (reset==0 at a clock edge) clears everything: board all 00, state IDLE, move_ready/move_ack/move_illegal/busy/game_over/draw=0, winner=00, move_count=0, turn=0.
- States: IDLE, WAIT_MOVE, CHECK, DONE.
- start (any state): next edge clears the board, zeroes move_count, game_over, draw and winner, sets turn=first_player, goes to WAIT_MOVE. start has priority over a same-cycle move_valid; that move is dropped with no ack and no illegal pulse.
- IDLE: move_ready=0; waits for start.
- WAIT_MOVE: move_ready=1. Handshake fires when move_valid & move_ready at edge t.
- A move is illegal if any of these hold: move_side!=turn; move_row>=N or move_col>=N; target cell non-empty.
- Illegal move: move_illegal=1 during cycle t+1. Board, turn and move_count are unchanged. The engine stays in WAIT_MOVE, so move_ready stays 1.
- Legal move, cycle t+1:
  - cell written (01/10), visible on rd_cell;
  - move_ack=1 and move_count incremented;
  - state CHECK, move_ready=0, busy=1.
- CHECK walks 4 directions in fixed order: row, column, main diagonal (+1,+1), anti-diagonal (+1,-1).
  - Each direction is walked forward, then backward.
  - Run counter starts at 1 per direction.
  - One neighbour cell is examined per cycle. An in-range cell of the same owner increments the run and continues. An out-of-range cell or a different/empty cell ends that half-walk and consumes its cycle.
  - When run reaches K, the walk stops immediately: win.
  - CHECK lasts at most 8*K cycles.
- CHECK exit, evaluated in the cycle it ends:
  - win → DONE, game_over=1, winner=mover's code, draw=0;
  - else move_count==N*N → DONE, game_over=1, draw=1, winner=00;
  - else turn toggles → WAIT_MOVE.
  - busy drops and the new state's outputs apply the cycle after the last examined cell.
- DONE: move_ready=0. move_valid is ignored (no ack, no illegal pulse). Outputs hold until start or reset.
- move_ack and move_illegal are never high together, and each is high for exactly one cycle per handshake.
- rd_cell is purely combinational from the board registers.

Test Plan:
- Reset low 2 cycles, release, start with first_player=0; player move (1,1) → move_ack at t+1, rd_cell(1,1)=01, move_count=1, busy high ≤24 cycles, then turn=1, move_ready=1.
- Illegal move cases, each → move_illegal for 1 cycle, board and move_count unchanged, move_ready=1:
  - computer moves on the player's turn;
  - row=3 with N=3;
  - player re-targets occupied cell (1,1).
- N=3: player at (0,0),(0,2),(0,1) with computer at (1,0),(1,1) → game_over=1, winner=01, draw=0 after final CHECK; a further move_valid gets no ack and no illegal pulse.
- N=5, K=4: computer at (0,4),(2,2),(3,1), then (1,3) placed last in mid-run → winner=10 (anti-diagonal, both walk directions); K-1=3-long runs elsewhere give no win.
- N=3, full non-winning sequence of 9 moves → draw=1, winner=00, move_count=9, game_over=1.
- start asserted during CHECK together with move_valid → board all 00, move_count=0, no ack, WAIT_MOVE next cycle. reset low mid-game → all outputs at reset values after that edge.

Source files
------------

// File: rtl/grid_game_engine.sv
// N x N, K-in-a-row two-party game engine: board, turn order, move check, line walk, win/draw.
// Ack/illegal one cycle after the handshake; CHECK examines one neighbour per cycle; move_ready low outside WAIT_MOVE.
module grid_game_engine #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int CW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      first_player_i,
    input  logic                      move_valid_i,
    output logic                      move_ready_o,
    input  logic                      move_side_i,
    input  logic [CW-1:0]             move_row_i,
    input  logic [CW-1:0]             move_col_i,
    output logic                      move_ack_o,
    output logic                      move_illegal_o,
    input  logic [CW-1:0]             rd_row_i,
    input  logic [CW-1:0]             rd_col_i,
    output logic [1:0]                rd_cell_o,
    output logic                      turn_o,
    output logic                      busy_o,
    output logic                      game_over_o,
    output logic [1:0]                winner_o,
    output logic                      draw_o,
    output logic [$clog2(N*N+1)-1:0]  move_count_o
);

    localparam int CELLS = N * N;
    localparam int MCW   = $clog2(N*N+1);
    localparam int RW    = $clog2(K+1);
    localparam int PW    = CW + 2;
    localparam logic [RW-1:0]  K_RUN    = RW'(K);
    localparam logic [MCW-1:0] FULL_CNT = MCW'(CELLS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;
    typedef logic signed [PW-1:0] pos_t;

    state_t               state_q, state_d;
    logic [2*CELLS-1:0]   board_q, board_d;
    logic                 turn_q, turn_d;
    logic [MCW-1:0]       cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 ill_q, ill_d;
    logic                 over_q, over_d;
    logic                 draw_q, draw_d;
    logic [1:0]           winner_q, winner_d;
    pos_t                 org_r_q, org_r_d, org_c_q, org_c_d;
    pos_t                 cur_r_q, cur_r_d, cur_c_q, cur_c_d;
    logic [1:0]           dir_q, dir_d;
    logic                 bwd_q, bwd_d;
    logic [RW-1:0]        run_q, run_d;
    logic [1:0]           mover_q, mover_d;

    pos_t                 dr, dc, nxt_r, nxt_c;
    logic [1:0]           nxt_cell, mv_cell, code;
    logic [RW-1:0]        run_inc;
    logic                 move_legal;

    // Off-board coordinates (including negative ones) read as empty.
    function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] b, input int r, input int c);
        logic [1:0] v;
        v = 2'b00;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (r == i && c == j) v = b[2*(i*N+j) +: 2];
            end
        end
        return v;
    endfunction

    always_comb begin
        dr = pos_t'(0);
        dc = pos_t'(1);
        case (dir_q)
            2'd0:    begin dr = pos_t'(0); dc = pos_t'(1);  end
            2'd1:    begin dr = pos_t'(1); dc = pos_t'(0);  end
            2'd2:    begin dr = pos_t'(1); dc = pos_t'(1);  end
            default: begin dr = pos_t'(1); dc = pos_t'(-1); end
        endcase
        if (bwd_q) begin
            dr = -dr;
            dc = -dc;
        end
        nxt_r      = cur_r_q + dr;
        nxt_c      = cur_c_q + dc;
        nxt_cell   = cell_at(board_q, int'(nxt_r), int'(nxt_c));
        mv_cell    = cell_at(board_q, int'(move_row_i), int'(move_col_i));
        code       = {turn_q, ~turn_q};
        run_inc    = run_q + 1'b1;
        move_legal = (move_side_i == turn_q) && (int'(move_row_i) < N) &&
                     (int'(move_col_i) < N) && (mv_cell == 2'b00);
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        ill_d    = 1'b0;
        over_d   = over_q;
        draw_d   = draw_q;
        winner_d = winner_q;
        org_r_d  = org_r_q;
        org_c_d  = org_c_q;
        cur_r_d  = cur_r_q;
        cur_c_d  = cur_c_q;
        dir_d    = dir_q;
        bwd_d    = bwd_q;
        run_d    = run_q;
        mover_d  = mover_q;
        if (start_i) begin
            board_d  = '0;
            cnt_d    = '0;
            over_d   = 1'b0;
            draw_d   = 1'b0;
            winner_d = 2'b00;
            turn_d   = first_player_i;
            state_d  = S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (move_valid_i) begin
                        if (!move_legal) begin
                            ill_d = 1'b1;
                        end else begin
                            for (int i = 0; i < N; i++) begin
                                for (int j = 0; j < N; j++) begin
                                    if (int'(move_row_i) == i && int'(move_col_i) == j)
                                        board_d[2*(i*N+j) +: 2] = code;
                                end
                            end
                            mover_d = code;
                            org_r_d = pos_t'({2'b00, move_row_i});
                            org_c_d = pos_t'({2'b00, move_col_i});
                            cur_r_d = pos_t'({2'b00, move_row_i});
                            cur_c_d = pos_t'({2'b00, move_col_i});
                            dir_d   = 2'd0;
                            bwd_d   = 1'b0;
                            run_d   = RW'(1);
                            cnt_d   = cnt_q + 1'b1;
                            ack_d   = 1'b1;
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (nxt_cell == mover_q) begin
                        if (run_inc == K_RUN) begin
                            state_d  = S_DONE;
                            over_d   = 1'b1;
                            winner_d = mover_q;
                            draw_d   = 1'b0;
                        end else begin
                            run_d   = run_inc;
                            cur_r_d = nxt_r;
                            cur_c_d = nxt_c;
                        end
                    end else if (!bwd_q) begin
                        // Backward half keeps the forward run count.
                        bwd_d   = 1'b1;
                        cur_r_d = org_r_q;
                        cur_c_d = org_c_q;
                    end else if (dir_q != 2'd3) begin
                        dir_d   = dir_q + 2'd1;
                        bwd_d   = 1'b0;
                        run_d   = RW'(1);
                        cur_r_d = org_r_q;
                        cur_c_d = org_c_q;
                    end else if (cnt_q == FULL_CNT) begin
                        state_d  = S_DONE;
                        over_d   = 1'b1;
                        draw_d   = 1'b1;
                        winner_d = 2'b00;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_WAIT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            turn_q   <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            ill_q    <= 1'b0;
            over_q   <= 1'b0;
            draw_q   <= 1'b0;
            winner_q <= 2'b00;
            org_r_q  <= '0;
            org_c_q  <= '0;
            cur_r_q  <= '0;
            cur_c_q  <= '0;
            dir_q    <= 2'd0;
            bwd_q    <= 1'b0;
            run_q    <= '0;
            mover_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            ill_q    <= ill_d;
            over_q   <= over_d;
            draw_q   <= draw_d;
            winner_q <= winner_d;
            org_r_q  <= org_r_d;
            org_c_q  <= org_c_d;
            cur_r_q  <= cur_r_d;
            cur_c_q  <= cur_c_d;
            dir_q    <= dir_d;
            bwd_q    <= bwd_d;
            run_q    <= run_d;
            mover_q  <= mover_d;
        end
    end

    assign move_ready_o   = (state_q == S_WAIT);
    assign busy_o         = (state_q == S_CHECK);
    assign move_ack_o     = ack_q;
    assign move_illegal_o = ill_q;
    assign turn_o         = turn_q;
    assign game_over_o    = over_q;
    assign winner_o       = winner_q;
    assign draw_o         = draw_q;
    assign move_count_o   = cnt_q;
    assign rd_cell_o      = cell_at(board_q, int'(rd_row_i), int'(rd_col_i));

endmodule

// File: tb/tb_grid_game_engine.sv
// Bench for grid_game_engine: a 3x3/K=3 and a 5x5/K=4 instance sharing stimulus, directed tables plus random games.
module tb_grid_game_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, fp, valid, side, sel;
    logic [2:0] row, col, rd_row, rd_col;
    logic       a_start, a_valid, b_start, b_valid;

    logic       a_ready, a_ack, a_ill, a_turn, a_busy, a_over, a_draw;
    logic [1:0] a_cell, a_win;
    logic [3:0] a_cnt;
    logic       b_ready, b_ack, b_ill, b_turn, b_busy, b_over, b_draw;
    logic [1:0] b_cell, b_win;
    logic [4:0] b_cnt;

    assign a_start = start & ~sel;
    assign a_valid = valid & ~sel;
    assign b_start = start & sel;
    assign b_valid = valid & sel;

    grid_game_engine #(.N(3), .K(3)) u_g3 (
        .clock_i(clk), .reset_i(reset_n), .start_i(a_start), .first_player_i(fp),
        .move_valid_i(a_valid), .move_ready_o(a_ready), .move_side_i(side),
        .move_row_i(row[1:0]), .move_col_i(col[1:0]), .move_ack_o(a_ack),
        .move_illegal_o(a_ill), .rd_row_i(rd_row[1:0]), .rd_col_i(rd_col[1:0]),
        .rd_cell_o(a_cell), .turn_o(a_turn), .busy_o(a_busy), .game_over_o(a_over),
        .winner_o(a_win), .draw_o(a_draw), .move_count_o(a_cnt)
    );

    grid_game_engine #(.N(5), .K(4)) u_g5 (
        .clock_i(clk), .reset_i(reset_n), .start_i(b_start), .first_player_i(fp),
        .move_valid_i(b_valid), .move_ready_o(b_ready), .move_side_i(side),
        .move_row_i(row), .move_col_i(col), .move_ack_o(b_ack),
        .move_illegal_o(b_ill), .rd_row_i(rd_row), .rd_col_i(rd_col),
        .rd_cell_o(b_cell), .turn_o(b_turn), .busy_o(b_busy), .game_over_o(b_over),
        .winner_o(b_win), .draw_o(b_draw), .move_count_o(b_cnt)
    );

    int v_ready, v_ack, v_ill, v_turn, v_busy, v_over, v_draw, v_cell, v_win, v_cnt;
    always_comb begin
        if (sel) begin
            v_ready = int'(b_ready); v_ack = int'(b_ack); v_ill = int'(b_ill);
            v_turn = int'(b_turn); v_busy = int'(b_busy); v_over = int'(b_over);
            v_draw = int'(b_draw); v_cell = int'(b_cell); v_win = int'(b_win); v_cnt = int'(b_cnt);
        end else begin
            v_ready = int'(a_ready); v_ack = int'(a_ack); v_ill = int'(a_ill);
            v_turn = int'(a_turn); v_busy = int'(a_busy); v_over = int'(a_over);
            v_draw = int'(a_draw); v_cell = int'(a_cell); v_win = int'(a_win); v_cnt = int'(a_cnt);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string nm, input int r, input int c, input int exp);
        rd_row = r[2:0];
        rd_col = c[2:0];
        #1;
        chk(nm, v_cell, exp);
    endtask

    task automatic do_start(input int f);
        fp    = f[0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One-edge request; returns pulses seen at t+1, busy length and stray pulses afterwards.
    task automatic do_move(input int s, input int r, input int c,
                           output int ack, output int ill, output int cyc, output int extra);
        side   = s[0];
        row    = r[2:0];
        col    = c[2:0];
        rd_row = r[2:0];
        rd_col = c[2:0];
        valid  = 1'b1;
        tick();
        valid  = 1'b0;
        ack = v_ack; ill = v_ill; cyc = 0; extra = 0;
        while (v_busy == 1 && cyc < 100) begin
            cyc++;
            tick();
            if (v_ack != 0 || v_ill != 0) extra++;
        end
        if (cyc == 0) begin
            tick();
            if (v_ack != 0 || v_ill != 0) extra++;
        end
    endtask

    // Reference model: board as an array, win found by counting same-owner cells along each line.
    int mb[8][8];
    int m_n, m_k, m_turn, m_cnt, m_over, m_win, m_draw;
    int DR[4] = '{0, 1, 1, 1};
    int DC[4] = '{1, 0, 1, -1};

    task automatic m_start(input int n, input int k, input int f);
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) mb[i][j] = 0;
        m_n = n; m_k = k; m_turn = f; m_cnt = 0; m_over = 0; m_win = 0; m_draw = 0;
    endtask

    task automatic m_move(input int s, input int r, input int c,
                          output int ack, output int ill, output int cyc);
        int code, won, run, rr, cc, sg, stop;
        ack = 0; ill = 0; cyc = 0;
        if (m_over != 0) return;
        if (s != m_turn || r >= m_n || c >= m_n || mb[r][c] != 0) begin
            ill = 1;
            return;
        end
        code = s + 1;
        mb[r][c] = code;
        m_cnt++;
        ack = 1;
        won = 0;
        for (int d = 0; d < 4 && won == 0; d++) begin
            run = 1;
            for (int h = 0; h < 2 && won == 0; h++) begin
                sg = (h == 0) ? 1 : -1;
                rr = r; cc = c; stop = 0;
                while (stop == 0) begin
                    rr += sg * DR[d];
                    cc += sg * DC[d];
                    cyc++;
                    if (rr >= 0 && rr < m_n && cc >= 0 && cc < m_n && mb[rr][cc] == code) begin
                        run++;
                        if (run == m_k) begin won = 1; stop = 1; end
                    end else begin
                        stop = 1;
                    end
                end
            end
        end
        if (won != 0) begin
            m_over = 1; m_win = code;
        end else if (m_cnt == m_n * m_n) begin
            m_over = 1; m_draw = 1;
        end else begin
            m_turn ^= 1;
        end
    endtask

    typedef struct {
        int side; int row; int col;
        int ack; int ill; int turn; int cnt; int over; int draw;
    } vec_t;

    vec_t tbl[14];
    int   fb[3][3];

    initial begin
        int a, il, cy, ex, ea, ei, ec, n, k, f, s, r, c, pk;
        int w_s[5], w_r[5], w_c[5];
        int q_s[7], q_r[7], q_c[7];

        // N=3 game from first_player=0: illegal cases interleaved with a full draw.
        tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0};
        tbl[2]  = '{1, 3, 0, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{1, 0, 1, 1, 0, 0, 2, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 1, 0, 2, 0, 0};
        tbl[5]  = '{0, 0, 2, 1, 0, 1, 3, 0, 0};
        tbl[6]  = '{1, 1, 1, 1, 0, 0, 4, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 1, 0, 4, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, 0, 1, 5, 0, 0};
        tbl[9]  = '{1, 1, 2, 1, 0, 0, 6, 0, 0};
        tbl[10] = '{0, 2, 1, 1, 0, 1, 7, 0, 0};
        tbl[11] = '{1, 2, 0, 1, 0, 0, 8, 0, 0};
        tbl[12] = '{0, 2, 2, 1, 0, 0, 9, 1, 1};
        tbl[13] = '{1, 2, 2, 0, 0, 0, 9, 1, 1};
        fb = '{'{1, 2, 1}, '{1, 2, 2}, '{2, 1, 1}};
        w_s = '{0, 1, 0, 1, 0}; w_r = '{0, 1, 0, 1, 0}; w_c = '{0, 0, 2, 1, 1};
        q_s = '{1, 0, 1, 0, 1, 0, 1}; q_r = '{0, 0, 2, 0, 3, 0, 1}; q_c = '{4, 0, 2, 1, 1, 2, 3};

        reset_n = 1'b0; start = 1'b0; fp = 1'b0; valid = 1'b0; side = 1'b0; sel = 1'b0;
        row = '0; col = '0; rd_row = 3'd1; rd_col = 3'd1;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            chk("rst_ready", v_ready, 0); chk("rst_busy", v_busy, 0);
            chk("rst_ack", v_ack, 0);     chk("rst_ill", v_ill, 0);
            chk("rst_over", v_over, 0);   chk("rst_win", v_win, 0);
            chk("rst_draw", v_draw, 0);   chk("rst_cnt", v_cnt, 0);
            chk("rst_turn", v_turn, 0);   chk("rst_cell", v_cell, 0);
        end
        sel = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("idle_ready", v_ready, 0);

        do_start(0);
        chk("start_ready", v_ready, 1);
        do_move(0, 1, 1, a, il, cy, ex);
        chk("first_ack", a, 1); chk("first_ill", il, 0); chk("first_extra", ex, 0);
        chk("first_busy_cycles", cy, 8);
        rd_chk("first_cell", 1, 1, 1);
        chk("first_cnt", v_cnt, 1); chk("first_turn", v_turn, 1); chk("first_ready", v_ready, 1);

        do_start(0);
        for (int i = 0; i < 14; i++) begin
            do_move(tbl[i].side, tbl[i].row, tbl[i].col, a, il, cy, ex);
            chk($sformatf("tbl%0d_ack", i), a, tbl[i].ack);
            chk($sformatf("tbl%0d_ill", i), il, tbl[i].ill);
            chk($sformatf("tbl%0d_extra", i), ex, 0);
            chk($sformatf("tbl%0d_turn", i), v_turn, tbl[i].turn);
            chk($sformatf("tbl%0d_cnt", i), v_cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d_over", i), v_over, tbl[i].over);
            chk($sformatf("tbl%0d_draw", i), v_draw, tbl[i].draw);
            chk($sformatf("tbl%0d_win", i), v_win, 0);
            chk($sformatf("tbl%0d_ready", i), v_ready, 1 - tbl[i].over);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                rd_chk($sformatf("draw_board_%0d%0d", i, j), i, j, fb[i][j]);

        do_start(0);
        for (int i = 0; i < 5; i++) begin
            do_move(w_s[i], w_r[i], w_c[i], a, il, cy, ex);
            chk($sformatf("win3_ack%0d", i), a, 1);
        end
        chk("win3_cycles", cy, 3); chk("win3_over", v_over, 1); chk("win3_winner", v_win, 1);
        chk("win3_draw", v_draw, 0); chk("win3_ready", v_ready, 0);
        do_move(1, 2, 2, a, il, cy, ex);
        chk("done_ack", a, 0); chk("done_ill", il, 0); chk("done_extra", ex, 0);
        chk("done_cnt", v_cnt, 5); rd_chk("done_cell", 2, 2, 0);

        sel = 1'b1;
        do_start(1);
        for (int i = 0; i < 7; i++) begin
            do_move(q_s[i], q_r[i], q_c[i], a, il, cy, ex);
            chk($sformatf("win5_ack%0d", i), a, 1);
            if (i == 5) chk("win5_run3_no_win", v_over, 0);
        end
        chk("win5_cycles", cy, 10); chk("win5_over", v_over, 1); chk("win5_winner", v_win, 2);
        chk("win5_draw", v_draw, 0); chk("win5_cnt", v_cnt, 7);

        sel = 1'b0;
        do_start(0);
        side = 1'b0; row = 3'd1; col = 3'd1; valid = 1'b1;
        tick();
        chk("chk_start_ack", v_ack, 1); chk("chk_start_busy", v_busy, 1);
        start = 1'b1;
        row = 3'd0; col = 3'd0;
        tick();
        start = 1'b0; valid = 1'b0;
        chk("restart_ready", v_ready, 1); chk("restart_busy", v_busy, 0);
        chk("restart_cnt", v_cnt, 0); chk("restart_ack", v_ack, 0); chk("restart_ill", v_ill, 0);
        rd_chk("restart_cell11", 1, 1, 0);
        start = 1'b1; valid = 1'b1; side = 1'b1;
        tick();
        start = 1'b0; valid = 1'b0;
        chk("startprio_ack", v_ack, 0); chk("startprio_ill", v_ill, 0); chk("startprio_cnt", v_cnt, 0);
        tick();
        chk("startprio_ack2", v_ack, 0); chk("startprio_ill2", v_ill, 0);

        do_start(1);
        do_move(1, 0, 0, a, il, cy, ex);
        do_move(0, 1, 1, a, il, cy, ex);
        chk("mid_turn", v_turn, 1); chk("mid_cnt", v_cnt, 2);
        reset_n = 1'b0;
        tick();
        chk("mrst_ready", v_ready, 0); chk("mrst_turn", v_turn, 0); chk("mrst_cnt", v_cnt, 0);
        chk("mrst_over", v_over, 0); chk("mrst_busy", v_busy, 0);
        rd_chk("mrst_cell00", 0, 0, 0); rd_chk("mrst_cell11", 1, 1, 0);
        reset_n = 1'b1;
        tick();

        for (int g = 0; g < 12; g++) begin
            sel = g[0];
            n = sel ? 5 : 3;
            k = sel ? 4 : 3;
            f = int'($urandom_range(0, 1));
            do_start(f);
            m_start(n, k, f);
            chk($sformatf("g%0d_start_turn", g), v_turn, f);
            pk = 0;
            for (int mv = 0; mv < 60; mv++) begin
                if (m_over != 0 && pk != 0) break;
                if (m_over != 0) pk = 1;
                s = ($urandom_range(0, 4) == 0) ? 1 - m_turn : m_turn;
                r = int'($urandom_range(0, n));
                c = int'($urandom_range(0, n));
                m_move(s, r, c, ea, ei, ec);
                do_move(s, r, c, a, il, cy, ex);
                chk($sformatf("g%0d_m%0d_ack", g, mv), a, ea);
                chk($sformatf("g%0d_m%0d_ill", g, mv), il, ei);
                chk($sformatf("g%0d_m%0d_extra", g, mv), ex, 0);
                if (ea != 0) chk($sformatf("g%0d_m%0d_cycles", g, mv), cy, ec);
                chk($sformatf("g%0d_m%0d_turn", g, mv), v_turn, m_turn);
                chk($sformatf("g%0d_m%0d_cnt", g, mv), v_cnt, m_cnt);
                chk($sformatf("g%0d_m%0d_over", g, mv), v_over, m_over);
                chk($sformatf("g%0d_m%0d_win", g, mv), v_win, m_win);
                chk($sformatf("g%0d_m%0d_draw", g, mv), v_draw, m_draw);
                chk($sformatf("g%0d_m%0d_ready", g, mv), v_ready, 1 - m_over);
                if (r < n && c < n) rd_chk($sformatf("g%0d_m%0d_cell", g, mv), r, c, mb[r][c]);
                else rd_chk($sformatf("g%0d_m%0d_oob", g, mv), r, c, 0);
            end
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    rd_chk($sformatf("g%0d_board_%0d%0d", g, i, j), i, j, mb[i][j]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "timeout");
    end

endmodule
